// File: rtl/mac_dot_pipe.sv
// mac_dot_pipe: two-stage pipelined multiply-accumulate over windows of LEN
// samples. Stage 1 registers the product, stage 2 accumulates it, and the
// last sample of each window produces a one-cycle result strobe.
//
// Input qualification: a/b are consumed on every rising edge where in_valid
// is 1. There is no backpressure, so the unit accepts one sample per clock.
// out_valid is a one-cycle strobe. result/overflow hold their values until
// the next strobe.
module mac_dot_pipe #(
    parameter int WIDTH     = 32,
    parameter int ACC_WIDTH = 64,
    parameter int LEN       = 4,
    parameter bit SIGNED    = 1'b0,
    parameter bit SATURATE  = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic                         clear,
    input  logic [WIDTH-1:0]             a,
    input  logic [WIDTH-1:0]             b,
    output logic [ACC_WIDTH-1:0]         acc_out,
    output logic [ACC_WIDTH-1:0]         result,
    output logic                         out_valid,
    output logic                         overflow,
    output logic [$clog2(LEN+1)-1:0]     sample_cnt
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(LEN + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(LEN - 1);

    // Stage-1 registers
    logic [PW-1:0]        prod_q;
    logic                 v1_q, first1_q, last1_q;
    logic [CW-1:0]        cnt_q, cnt_d, cnt_eff;
    logic                 first_d, last_d;
    logic [PW-1:0]        prod_d;

    // Stage-2 registers
    logic [ACC_WIDTH-1:0] acc_q, result_q;
    logic                 ovf_q, overflow_q, out_valid_q;

    // Stage-2 combinational datapath
    logic [ACC_WIDTH-1:0] ext_prod, base, sum_raw, sum_sat, sum;
    logic [ACC_WIDTH:0]   sum_full;
    logic                 ovf_now, ovf_win;

    // Product at full 2*WIDTH precision. For signed mode the operands are
    // sign-extended first. The low 2*WIDTH bits of that product equal the
    // two's-complement product.
    always_comb begin
        if (SIGNED)
            prod_d = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
        else
            prod_d = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    end

    // Sample index: a clear restarts the window, so a sample that arrives
    // together with the clear becomes index 0 of the new window.
    always_comb begin
        cnt_eff = clear ? '0 : cnt_q;
        first_d = (cnt_eff == '0);
        last_d  = (cnt_eff == LAST_IDX);
        if (in_valid)
            cnt_d = last_d ? '0 : cnt_eff + CW'(1);
        else
            cnt_d = cnt_eff;
    end

    // Widen the product to the accumulator width.
    generate
        if (ACC_WIDTH > PW) begin : g_ext
            assign ext_prod = SIGNED ? {{(ACC_WIDTH-PW){prod_q[PW-1]}}, prod_q}
                                     : {{(ACC_WIDTH-PW){1'b0}}, prod_q};
        end else begin : g_noext
            assign ext_prod = prod_q;
        end
    endgenerate

    // Accumulate, detect overflow, and optionally clamp.
    always_comb begin
        base     = first1_q ? '0 : acc_q;
        sum_full = {1'b0, base} + {1'b0, ext_prod};
        sum_raw  = sum_full[ACC_WIDTH-1:0];
        if (SIGNED)
            ovf_now = (base[ACC_WIDTH-1] == ext_prod[ACC_WIDTH-1]) &&
                      (sum_raw[ACC_WIDTH-1] != base[ACC_WIDTH-1]);
        else
            ovf_now = sum_full[ACC_WIDTH];
        // The clamp direction follows the sign shared by both operands.
        if (!SIGNED)
            sum_sat = '1;
        else if (base[ACC_WIDTH-1])
            sum_sat = {1'b1, {(ACC_WIDTH-1){1'b0}}};
        else
            sum_sat = {1'b0, {(ACC_WIDTH-1){1'b1}}};
        sum     = (SATURATE && ovf_now) ? sum_sat : sum_raw;
        // The sticky flag restarts at the first sample of each window.
        ovf_win = (first1_q ? 1'b0 : ovf_q) | ovf_now;
    end

    // Stage 1: capture the product and window position of each accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q   <= '0;
            v1_q     <= 1'b0;
            first1_q <= 1'b0;
            last1_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            v1_q  <= in_valid;
            cnt_q <= cnt_d;
            if (in_valid) begin
                prod_q   <= prod_d;
                first1_q <= first_d;
                last1_q  <= last_d;
            end
        end
    end

    // Stage 2: accumulate and publish the window result. A clear drops the
    // product currently in stage 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (clear) begin
                acc_q <= '0;
                ovf_q <= 1'b0;
            end else if (v1_q) begin
                acc_q <= sum;
                ovf_q <= ovf_win;
                if (last1_q) begin
                    result_q    <= sum;
                    overflow_q  <= ovf_win;
                    out_valid_q <= 1'b1;
                end
            end
        end
    end

    assign acc_out    = acc_q;
    assign result     = result_q;
    assign overflow   = overflow_q;
    assign out_valid  = out_valid_q;
    assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_mac_dot_pipe.sv
// Testbench for mac_dot_pipe. Four instances cover the default 32/64 unit,
// signed 8/16, unsigned saturating 8/16, and unsigned wrapping 8/16.
module tb_mac_dot_pipe;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- DUT signals ----------------
    logic        v0 = 0, c0 = 0;
    logic [31:0] a0 = '0, b0 = '0;
    logic [63:0] acc0, res0;
    logic        ov0, ovf0;
    logic [2:0]  cnt0;

    logic        vs = 0, vu = 0, clr_s = 0, clr_u = 0;
    logic [7:0]  as = '0, bs = '0, au = '0, bu = '0;
    logic [15:0] acc1, res1, acc2, res2, acc3, res3;
    logic        ov1, ovf1, ov2, ovf2, ov3, ovf3;
    logic [1:0]  cnt1, cnt2, cnt3;

    mac_dot_pipe u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(v0), .clear(c0), .a(a0), .b(b0),
        .acc_out(acc0), .result(res0), .out_valid(ov0), .overflow(ovf0),
        .sample_cnt(cnt0)
    );

    mac_dot_pipe #(.WIDTH(8), .ACC_WIDTH(16), .LEN(2), .SIGNED(1), .SATURATE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(vs), .clear(clr_s), .a(as), .b(bs),
        .acc_out(acc1), .result(res1), .out_valid(ov1), .overflow(ovf1),
        .sample_cnt(cnt1)
    );

    mac_dot_pipe #(.WIDTH(8), .ACC_WIDTH(16), .LEN(2), .SIGNED(0), .SATURATE(1)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(vu), .clear(clr_u), .a(au), .b(bu),
        .acc_out(acc2), .result(res2), .out_valid(ov2), .overflow(ovf2),
        .sample_cnt(cnt2)
    );

    mac_dot_pipe #(.WIDTH(8), .ACC_WIDTH(16), .LEN(2), .SIGNED(0), .SATURATE(0)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(vu), .clear(clr_u), .a(au), .b(bu),
        .acc_out(acc3), .result(res3), .out_valid(ov3), .overflow(ovf3),
        .sample_cnt(cnt3)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [64:0] exp0_q[$];   // {overflow, result}
    logic [16:0] exp1_q[$];
    logic [16:0] exp2_q[$];
    logic [16:0] exp3_q[$];
    int last_strobe = 0;
    int prev_strobe = 0;

    task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string nm);
        total++;
        bad++;
        $display("FAIL %s: strobe with empty expected queue (t=%0t)", nm, $time);
    endtask

    // Monitors: outputs are sampled on the falling edge.
    always @(negedge clk) begin
        logic [64:0] e;
        if (rst_n && ov0) begin
            prev_strobe = last_strobe;
            last_strobe = cyc;
            if (exp0_q.size() == 0) unexpected("u0");
            else begin
                e = exp0_q.pop_front();
                chk("u0 result", {1'b0, res0}, {1'b0, e[63:0]});
                chk("u0 overflow", {64'd0, ovf0}, {64'd0, e[64]});
            end
        end
    end

    always @(negedge clk) begin
        logic [16:0] e;
        if (rst_n && ov1) begin
            if (exp1_q.size() == 0) unexpected("u1");
            else begin
                e = exp1_q.pop_front();
                chk("u1 signed result", {49'd0, res1}, {49'd0, e[15:0]});
                chk("u1 signed overflow", {64'd0, ovf1}, {64'd0, e[16]});
            end
        end
    end

    always @(negedge clk) begin
        logic [16:0] e;
        if (rst_n && ov2) begin
            if (exp2_q.size() == 0) unexpected("u2");
            else begin
                e = exp2_q.pop_front();
                chk("u2 sat result", {49'd0, res2}, {49'd0, e[15:0]});
                chk("u2 sat overflow", {64'd0, ovf2}, {64'd0, e[16]});
            end
        end
    end

    always @(negedge clk) begin
        logic [16:0] e;
        if (rst_n && ov3) begin
            if (exp3_q.size() == 0) unexpected("u3");
            else begin
                e = exp3_q.pop_front();
                chk("u3 wrap result", {49'd0, res3}, {49'd0, e[15:0]});
                chk("u3 wrap overflow", {64'd0, ovf3}, {64'd0, e[16]});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drv0(input logic v, input logic c, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        v0 = v; c0 = c; a0 = a; b0 = b;
    endtask

    task automatic idle0(input int n);
        for (int i = 0; i < n; i++) drv0(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic drv_s(input logic v, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        vs = v; as = a; bs = b;
    endtask

    task automatic drv_u(input logic v, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        vu = v; au = a; bu = b;
    endtask

    task automatic chk_u0_zero(input string nm);
        chk({nm, " acc_out"}, {1'b0, acc0}, 65'd0);
        chk({nm, " result"}, {1'b0, res0}, 65'd0);
        chk({nm, " out_valid"}, {64'd0, ov0}, 65'd0);
        chk({nm, " overflow"}, {64'd0, ovf0}, 65'd0);
        chk({nm, " sample_cnt"}, {62'd0, cnt0}, 65'd0);
    endtask

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    logic [31:0] va[8];
    logic [31:0] vb[8];

    initial begin
        va = '{32'd5, 32'd12, 32'd10, 32'd4, 32'd5, 32'd2, 32'd451, 32'd12};
        vb = '{32'd6, 32'd5, 32'd10, 32'd2, 32'd150, 32'd15, 32'd123, 32'd1680};

        // Reset state
        repeat (3) @(negedge clk);
        chk_u0_zero("reset");
        rst_n = 1'b1;

        // Two back-to-back windows with in_valid held high.
        // Window 1: 30+60+100+8 = 198. Window 2: 750+30+55473+20160 = 76413.
        exp0_q.push_back({1'b0, 64'd198});
        exp0_q.push_back({1'b0, 64'd76413});
        for (int i = 0; i < 8; i++) begin
            drv0(1'b1, 1'b0, va[i], vb[i]);
            if (i == 6) chk("acc_out restart", {1'b0, acc0}, 65'd750);
        end
        idle0(4);
        chk("strobe spacing", 65'(last_strobe - prev_strobe), 65'd4);

        // Bubbles: two idle cycles between samples.
        exp0_q.push_back({1'b0, 64'd198});
        for (int k = 0; k < 4; k++) begin
            drv0(1'b1, 1'b0, va[k], vb[k]);
            chk("bubble sample_cnt", {62'd0, cnt0}, 65'(k));
            if (k < 3) idle0(2);
        end
        idle0(1);
        chk("bubble no early strobe", {64'd0, ov0}, 65'd0);
        idle0(1);
        chk("bubble strobe latency", {64'd0, ov0}, 65'd1);
        chk("bubble sample_cnt wrap", {62'd0, cnt0}, 65'd0);
        idle0(3);

        // Clear on the 3rd sample, which starts the new window:
        // 100 + 8 + 1 + 4 = 113.
        exp0_q.push_back({1'b0, 64'd113});
        drv0(1'b1, 1'b0, 32'd5, 32'd6);
        drv0(1'b1, 1'b0, 32'd12, 32'd5);
        drv0(1'b1, 1'b1, 32'd10, 32'd10);
        drv0(1'b1, 1'b0, 32'd4, 32'd2);
        chk("clear sample_cnt", {62'd0, cnt0}, 65'd1);
        chk("clear acc_out", {1'b0, acc0}, 65'd0);
        drv0(1'b1, 1'b0, 32'd1, 32'd1);
        drv0(1'b1, 1'b0, 32'd2, 32'd2);
        idle0(4);

        // Reset mid-window: outputs clear at once and no strobe follows.
        drv0(1'b1, 1'b0, 32'd5, 32'd6);
        drv0(1'b1, 1'b0, 32'd12, 32'd5);
        idle0(1);
        rst_n = 1'b0;
        #1;
        chk_u0_zero("async reset");
        idle0(3);
        rst_n = 1'b1;
        exp0_q.push_back({1'b0, 64'd198});
        for (int k = 0; k < 4; k++) drv0(1'b1, 1'b0, va[k], vb[k]);
        idle0(4);

        // Signed 8-bit: (-3*7) + (4*-5) = -41 = 16'hFFD7.
        exp1_q.push_back({1'b0, 16'hFFD7});
        drv_s(1'b1, 8'hFD, 8'd7);
        drv_s(1'b1, 8'd4, 8'hFB);
        drv_s(1'b0, 8'd0, 8'd0);

        // Unsigned 8-bit: 65025 + 65025 = 130050 overflows 16 bits.
        // Saturating: 65535. Wrapping: 130050 - 65536 = 64514.
        // The following window, 1 + 1 = 2, must report overflow cleared.
        exp2_q.push_back({1'b1, 16'd65535});
        exp3_q.push_back({1'b1, 16'd64514});
        exp2_q.push_back({1'b0, 16'd2});
        exp3_q.push_back({1'b0, 16'd2});
        drv_u(1'b1, 8'd255, 8'd255);
        drv_u(1'b1, 8'd255, 8'd255);
        drv_u(1'b1, 8'd1, 8'd1);
        drv_u(1'b1, 8'd1, 8'd1);
        drv_u(1'b0, 8'd0, 8'd0);
        repeat (5) @(negedge clk);

        // Every expected result must have been seen.
        chk("u0 queue drained", 65'(exp0_q.size()), 65'd0);
        chk("u1 queue drained", 65'(exp1_q.size()), 65'd0);
        chk("u2 queue drained", 65'(exp2_q.size()), 65'd0);
        chk("u3 queue drained", 65'(exp3_q.size()), 65'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_dot_pipe.md
Name: mac_dot_pipe

Overview:
- Parametrised, pipelined multiply-accumulate unit; next generation of the 32-bit MAC.
- Accumulates valid-qualified products over a programmable window of LEN samples, then emits a one-cycle result strobe and restarts automatically.
- Adds signed/unsigned mode, saturation or wrap, a sticky overflow flag, a synchronous clear, and tolerance of input bubbles.
- Sits in the datapath as a dot-product / FIR-tap engine fed by a streaming source.

Parameters:
- WIDTH, 32, operand width a/b.
- ACC_WIDTH, 64, accumulator/result width; must be >= 2*WIDTH.
- LEN, 4, samples per accumulation window; must be >= 1.
- SIGNED, 0, 1 = two's-complement operands/accumulator, 0 = unsigned.
- SATURATE, 1, 1 = clamp on overflow, 0 = wrap modulo 2^ACC_WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  a/b valid this cycle.
- clear  in  1  synchronous abort of current window.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- acc_out  out  ACC_WIDTH  running accumulator.
- result  out  ACC_WIDTH  completed window sum; held until next strobe.
- out_valid  out  1  one-cycle strobe, result updated.
- overflow  out  1  overflow occurred in the window just reported; valid with out_valid, held with result.
- sample_cnt  out  $clog2(LEN+1)  samples accepted in current window.

Behaviour:
- Reset (rst_n=0, async): all outputs 0; cnt=0; stage-1 valid=0; internal sticky ovf=0. Reset mid-window discards all in-flight data; no out_valid follows.
- Stage 1 (edge E0): if in_valid, register prod = a*b at 2*WIDTH bits (signed or unsigned per SIGNED). Also register v1=1, first1=(cnt==0), last1=(cnt==LEN-1). Otherwise v1=0.
- Counter: on accepted sample, cnt increments; at LEN-1 it wraps to 0. sample_cnt = cnt.
- Stage 2 (edge E1, when v1): base = first1 ? 0 : acc. sum = base + extend(prod) (sign- or zero-extended to ACC_WIDTH). acc_out <= sum.
- Overflow detection on the sum:
  - Unsigned: carry out.
  - Signed: operands same sign and result sign differs.
  - SATURATE=1: clamp to 2^ACC_WIDTH-1 (unsigned) or to +max / -min (signed, direction of the true result).
  - SATURATE=0: wrapped sum.
- Sticky ovf: set on overflow; reloaded (not OR'd) on first1.
- Window end: if last1, then at E1 result <= sum, overflow <= ovf|this-cycle overflow, out_valid=1 for exactly one cycle. Latency: last sample presented before E0 gives out_valid high after E1 (2 clocks).
- Bubbles (in_valid=0): no state change in cnt/acc; the window simply stretches.
- LEN=1: every sample emits a result equal to its product.
- Clear at edge Ec:
  - acc_out<=0, ovf<=0.
  - Stage-1 contents from the previous cycle are discarded (no accumulate, no strobe).
  - If in_valid is also 1 that cycle, the sample is accepted as index 0 of the new window (cnt<=1; with LEN=1, cnt<=0 and it is also last1). Otherwise cnt<=0.
  - result/overflow unchanged; out_valid=0 that cycle.
- Back-to-back windows: last sample of window N and first of window N+1 on consecutive cycles is legal; no gap cycle is required.

Test Plan:
- Defaults, unsigned, continuous in_valid: (5,6),(12,5),(10,10),(4,2) then (5,150),(2,15),(451,123),(12,1680) -> out_valid twice, 4 cycles apart; result=198, then result=76413; overflow=0; acc_out resets to 750 on the first sample of window 2.
- Bubbles: same first window with in_valid low 2 cycles between each sample -> result=198, single strobe 2 clocks after the 4th sample; sample_cnt sequence 0,1,2,3,0.
- SIGNED=1, WIDTH=8, ACC_WIDTH=16, LEN=2: (-3,7),(4,-5) -> result=16'hFFD7 (-41), overflow=0.
- WIDTH=8, ACC_WIDTH=16, LEN=2, unsigned, (255,255)x2:
  - SATURATE=1 -> result=65535, overflow=1.
  - SATURATE=0 -> result=64514, overflow=1.
  - Next window (1,1),(1,1) -> result=2, overflow=0.
- Clear and reset mid-window, defaults:
  - Send (5,6),(12,5), assert clear with (10,10) on the 3rd sample, then (4,2),(1,1),(2,2) -> result=100+8+1+4=113.
  - Separately, assert rst_n=0 after 2 samples -> all outputs 0 immediately, no strobe; next full window sums correctly.
